// File: rtl/rpn_cpu.sv
// RPN calculator core: synchronised button edges drive a small micro-sequencer
// operating on an 8-entry signed stack; outputs are refreshed in the UPD step.
module rpn_cpu #(
   parameter int DEPTH     = 8,
   parameter int SLOW_BITS = 24
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic [7:0] Din,
   input  logic       Sample,
   input  logic [2:0] Btns,
   input  logic       Turbo,
   output logic [7:0] Dout,
   output logic       Dval,
   output logic [5:0] GPO,
   output logic [3:0] Debug,
   output logic [7:0] IP
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = $clog2(DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [7:0] {
      S_INIT = 8'h00,
      S_IDLE = 8'h01,
      S_PUSH = 8'h10,
      S_POP  = 8'h20,
      S_ADD  = 8'h30,
      S_MUL  = 8'h40,
      S_UPD  = 8'h50
   } state_t;

   typedef enum logic [1:0] {R_PUSH, R_POP, R_ADD, R_MUL} req_t;

   state_t state_q, state_d;
   req_t   req_q, req_d;
   logic   pend_q, pend_d;
   logic [3:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
   logic [SLOW_BITS-1:0] slow_q, slow_d;
   logic signed [7:0] stack_q [DEPTH];
   logic signed [7:0] stack_d [DEPTH];
   logic [CW-1:0] cnt_q, cnt_d;
   logic err_q, err_d, ovf_q, ovf_d;
   logic [7:0] dout_q, dout_d;
   logic dval_q, dval_d;
   logic [5:0] gpo_q, gpo_d;

   logic step;
   logic [3:0] edge_v;
   logic [IW-1:0] top_idx, sec_idx;
   logic signed [7:0] op_a, op_b;
   logic signed [8:0] sum;
   logic signed [15:0] prod;

   assign step = Turbo | (slow_q == '1);

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) state_q <= S_INIT;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (step) begin
         case (state_q)
            S_INIT: state_d = S_IDLE;
            S_IDLE:
               if (pend_q) begin
                  case (req_q)
                     R_PUSH:  state_d = S_PUSH;
                     R_POP:   state_d = S_POP;
                     R_ADD:   state_d = S_ADD;
                     default: state_d = S_MUL;
                  endcase
               end
            S_PUSH, S_POP, S_ADD, S_MUL: state_d = S_UPD;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      IP   = state_q;
      Dout = dout_q;
      Dval = dval_q;
      GPO  = gpo_q;
      case (state_q)
         S_INIT:  Debug = 4'd0;
         S_IDLE:  Debug = 4'd1;
         S_PUSH:  Debug = 4'd2;
         S_POP:   Debug = 4'd3;
         S_ADD:   Debug = 4'd4;
         S_MUL:   Debug = 4'd5;
         S_UPD:   Debug = 4'd6;
         default: Debug = 4'd0;
      endcase
   end

   always_comb begin
      sync1_d = {Sample, Btns};
      sync2_d = sync1_q;
      prev_d  = sync2_q;
      edge_v  = sync2_q & ~prev_q;
      slow_d  = slow_q + SLOW_BITS'(1);
      pend_d  = pend_q;
      req_d   = req_q;
      // Requests are accepted only while the sequencer waits; the clear on dispatch wins.
      if (step && state_q == S_IDLE && pend_q) begin
         pend_d = 1'b0;
      end else if (!pend_q && (state_q == S_INIT || state_q == S_IDLE) && (edge_v != '0)) begin
         pend_d = 1'b1;
         if (edge_v[3])      req_d = R_PUSH;
         else if (edge_v[2]) req_d = R_POP;
         else if (edge_v[1]) req_d = R_ADD;
         else                req_d = R_MUL;
      end
   end

   always_comb begin
      stack_d = stack_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      ovf_d   = ovf_q;
      dout_d  = dout_q;
      dval_d  = dval_q;
      gpo_d   = gpo_q;
      top_idx = IW'(cnt_q - CW'(1));
      sec_idx = IW'(cnt_q - CW'(2));
      op_a    = stack_q[top_idx];
      op_b    = stack_q[sec_idx];
      sum     = 9'(op_b) + 9'(op_a);
      prod    = 16'(op_b) * 16'(op_a);
      if (step) begin
         case (state_q)
            S_PUSH:
               if (cnt_q < DEPTH_C) begin
                  stack_d[IW'(cnt_q)] = Din;
                  cnt_d = cnt_q + CW'(1);
                  err_d = 1'b0;
               end else begin
                  err_d = 1'b1;
               end
            S_POP:
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CW'(1);
                  err_d = 1'b0;
               end else begin
                  err_d = 1'b1;
               end
            S_ADD, S_MUL:
               if (cnt_q >= CW'(2)) begin
                  cnt_d = cnt_q - CW'(1);
                  err_d = 1'b0;
                  if (state_q == S_ADD) begin
                     stack_d[sec_idx] = sum[7:0];
                     ovf_d = sum[8] != sum[7];
                  end else begin
                     stack_d[sec_idx] = prod[7:0];
                     ovf_d = (prod[15:7] != '0) && (prod[15:7] != '1);
                  end
               end else begin
                  err_d = 1'b1;
               end
            S_UPD: begin
               dout_d = (cnt_q == '0) ? '0 : op_a;
               dval_d = cnt_q != '0;
               gpo_d  = {err_q, ovf_q, 4'(cnt_q)};
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
         slow_q  <= '0;
         pend_q  <= 1'b0;
         req_q   <= R_PUSH;
         stack_q <= '{default: '0};
         cnt_q   <= '0;
         err_q   <= 1'b0;
         ovf_q   <= 1'b0;
         dout_q  <= '0;
         dval_q  <= 1'b0;
         gpo_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
         slow_q  <= slow_d;
         pend_q  <= pend_d;
         req_q   <= req_d;
         stack_q <= stack_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         ovf_q   <= ovf_d;
         dout_q  <= dout_d;
         dval_q  <= dval_d;
         gpo_q   <= gpo_d;
      end
   end

endmodule

// File: tb/tb_rpn_cpu.sv
// Bench for rpn_cpu: directed vector table, randomized commands against a
// queue-based stack model, and hand sequences for slow stepping and reset abort.
module tb_rpn_cpu;

   localparam int C_PUSH = 0;
   localparam int C_POP  = 1;
   localparam int C_ADD  = 2;
   localparam int C_MUL  = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] din;
   logic       sample;
   logic [2:0] btns;
   logic       turbo;
   logic [7:0] dout;
   logic       dval;
   logic [5:0] gpo;
   logic [3:0] debug;
   logic [7:0] ip;

   int n_tests = 0;
   int n_fail  = 0;

   rpn_cpu #(.DEPTH(8), .SLOW_BITS(4)) dut (
      .Clock(clk), .Reset(rst), .Din(din), .Sample(sample), .Btns(btns),
      .Turbo(turbo), .Dout(dout), .Dval(dval), .GPO(gpo), .Debug(debug), .IP(ip)
   );

   always #10 clk = ~clk;

   typedef struct {
      int         cmd;
      logic [7:0] din;
      logic [7:0] dout;
      logic       dval;
      logic [3:0] cnt;
      logic       err;
      logic       ovf;
   } vec_t;

   vec_t vecs[$];

   function automatic void add_vec(int cmd, int d, int e_dout, int e_cnt, bit e_err, bit e_ovf);
      vec_t v;
      v.cmd  = cmd;
      v.din  = d[7:0];
      v.dout = e_dout[7:0];
      v.dval = (e_cnt != 0);
      v.cnt  = e_cnt[3:0];
      v.err  = e_err;
      v.ovf  = e_ovf;
      vecs.push_back(v);
   endfunction

   // Reference model: plain integer stack
   int stk[$];
   bit m_err, m_ovf;

   function automatic int wrap8(int r);
      logic signed [7:0] t;
      t = r[7:0];
      return int'(t);
   endfunction

   function automatic void model_reset();
      stk.delete();
      m_err = 0;
      m_ovf = 0;
   endfunction

   function automatic void model_apply(int cmd, logic [7:0] d);
      int a, b, r;
      logic signed [7:0] sd;
      sd = d;
      if (cmd == C_PUSH) begin
         if (stk.size() < 8) begin stk.push_back(int'(sd)); m_err = 0; end
         else m_err = 1;
      end else if (cmd == C_POP) begin
         if (stk.size() >= 1) begin void'(stk.pop_back()); m_err = 0; end
         else m_err = 1;
      end else begin
         if (stk.size() >= 2) begin
            a = stk.pop_back();
            b = stk.pop_back();
            r = (cmd == C_ADD) ? b + a : b * a;
            m_ovf = (r > 127) || (r < -128);
            stk.push_back(wrap8(r));
            m_err = 0;
         end else m_err = 1;
      end
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_model(input string name);
      int top;
      logic [7:0] e_dout;
      logic [3:0] e_cnt;
      e_dout = '0;
      if (stk.size() > 0) begin
         top = stk[stk.size() - 1];
         e_dout = top[7:0];
      end
      e_cnt = 4'(stk.size());
      check({name, "_dout"}, 16'(dout), 16'(e_dout));
      check({name, "_dval"}, 16'(dval), 16'(stk.size() > 0));
      check({name, "_gpo"}, 16'(gpo), 16'({m_err, m_ovf, e_cnt}));
   endtask

   task automatic press(input int cmd, input logic [7:0] d);
      @(negedge clk);
      din = d;
      case (cmd)
         C_PUSH:  sample = 1'b1;
         C_POP:   btns = 3'b100;
         C_ADD:   btns = 3'b010;
         default: btns = 3'b001;
      endcase
      @(negedge clk);
      sample = 1'b0;
      btns   = 3'b000;
   endtask

   task automatic wait_done(input int budget);
      int t;
      t = 0;
      while (ip == 8'h01 && t < budget) begin @(posedge clk); #1; t++; end
      if (t >= budget) begin
         n_tests++; n_fail++;
         $display("FAIL start_timeout: got ip %0h expected leave 01", ip);
      end
      t = 0;
      while (ip != 8'h01 && t < budget) begin @(posedge clk); #1; t++; end
      if (t >= budget) begin
         n_tests++; n_fail++;
         $display("FAIL done_timeout: got ip %0h expected 01", ip);
      end
   endtask

   task automatic run_cmd(input int cmd, input logic [7:0] d);
      press(cmd, d);
      wait_done(60);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      int t;
      int r;
      logic [7:0] d;

      rst = 1'b1; din = '0; sample = 1'b0; btns = '0; turbo = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_ip", 16'(ip), 16'h00);
      check("rst_debug", 16'(debug), 16'd0);
      check("rst_gpo", 16'(gpo), 16'h00);
      @(negedge clk);
      rst = 1'b0;
      repeat (50) @(posedge clk);
      #1;
      check("init_ip", 16'(ip), 16'h01);
      check("init_debug", 16'(debug), 16'd1);
      check("init_dval", 16'(dval), 16'd0);
      check("init_gpo", 16'(gpo), 16'h00);
      check("init_dout", 16'(dout), 16'h00);

      add_vec(C_PUSH, 2, 2, 1, 0, 0);
      add_vec(C_PUSH, 5, 5, 2, 0, 0);
      add_vec(C_ADD, 0, 7, 1, 0, 0);
      add_vec(C_PUSH, -3, -3, 2, 0, 0);
      add_vec(C_MUL, 0, -21, 1, 0, 0);
      add_vec(C_POP, 0, 0, 0, 0, 0);
      add_vec(C_POP, 0, 0, 0, 1, 0);
      for (int i = 1; i <= 6; i++) add_vec(C_PUSH, i, i, i, 0, 0);
      add_vec(C_MUL, 0, 30, 5, 0, 0);
      add_vec(C_MUL, 0, 120, 4, 0, 0);
      add_vec(C_MUL, 0, 104, 3, 0, 1);
      add_vec(C_MUL, 0, -48, 2, 0, 1);
      add_vec(C_MUL, 0, -48, 1, 0, 0);
      add_vec(C_POP, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 8; i++) add_vec(C_PUSH, 10 * i, 10 * i, i, 0, 0);
      add_vec(C_PUSH, 90, 80, 8, 1, 0);
      for (int i = 7; i >= 1; i--) add_vec(C_POP, 0, 10 * i, i, 0, 0);
      add_vec(C_ADD, 0, 10, 1, 1, 0);
      add_vec(C_PUSH, 127, 127, 2, 0, 0);
      add_vec(C_ADD, 0, -119, 1, 0, 1);
      add_vec(C_PUSH, 5, 5, 2, 0, 1);
      add_vec(C_POP, 0, -119, 1, 0, 1);
      add_vec(C_POP, 0, 0, 0, 0, 1);
      add_vec(C_ADD, 0, 0, 0, 1, 1);

      for (int i = 0; i < vecs.size(); i++) begin
         run_cmd(vecs[i].cmd, vecs[i].din);
         check($sformatf("vec%0d_dout", i), 16'(dout), 16'(vecs[i].dout));
         check($sformatf("vec%0d_dval", i), 16'(dval), 16'(vecs[i].dval));
         check($sformatf("vec%0d_gpo", i), 16'(gpo),
               16'({vecs[i].err, vecs[i].ovf, vecs[i].cnt}));
      end

      // Reset in the middle of a slow-stepped PUSH
      turbo = 1'b0;
      press(C_PUSH, 8'd33);
      t = 0;
      while (ip != 8'h10 && t < 200) begin @(posedge clk); #1; t++; end
      check("abort_reach_push", 16'(ip), 16'h10);
      #2 rst = 1'b1;
      #1;
      check("abort_ip", 16'(ip), 16'h00);
      check("abort_gpo", 16'(gpo), 16'h00);
      check("abort_dval", 16'(dval), 16'd0);
      @(negedge clk);
      rst = 1'b0;
      turbo = 1'b1;
      model_reset();
      repeat (10) @(posedge clk);
      #1;
      check("abort_idle_ip", 16'(ip), 16'h01);
      check_model("abort_state");

      // Simultaneous Push and Add/Mult edges: only Push runs
      @(negedge clk);
      din = 8'd7; sample = 1'b1; btns = 3'b011;
      @(negedge clk);
      sample = 1'b0; btns = 3'b000;
      wait_done(60);
      model_apply(C_PUSH, 8'd7);
      check_model("prio");
      repeat (20) @(posedge clk);
      #1;
      check("prio_dropped_ip", 16'(ip), 16'h01);
      check_model("prio_after");

      for (int i = 0; i < 150; i++) begin
         r = $urandom_range(0, 9);
         d = 8'($urandom);
         if (r < 4)      t = C_PUSH;
         else if (r < 6) t = C_POP;
         else if (r < 8) t = C_ADD;
         else            t = C_MUL;
         run_cmd(t, d);
         model_apply(t, d);
         check_model($sformatf("rnd%0d", i));
      end

      // Slow stepping with a single 25 ns Push pulse
      turbo = 1'b0;
      @(posedge clk);
      #3;
      din = 8'd42;
      sample = 1'b1;
      #25 sample = 1'b0;
      seen = 0;
      t = 0;
      while (t < 300) begin
         @(posedge clk); #1; t++;
         if (ip == 8'h10 && !seen) begin
            seen = 1;
            check("slow_debug", 16'(debug), 16'd2);
         end
         if (seen && ip == 8'h01) break;
      end
      check("slow_visit_push", 16'(seen), 16'd1);
      check("slow_back_idle", 16'(ip), 16'h01);
      model_apply(C_PUSH, 8'd42);
      check_model("slow");
      turbo = 1'b1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
